// File: rtl/adc_pkg.sv
// Shared definitions for the dual-channel SPI ADC front end and its downstream stages.
// The sample-pair type is common to the ADC interface stage and the averaging filter.
package adc_pkg;

    localparam int ADC_DATA_W   = 12;
    localparam int AVG_LOG2_MAX = 8;

    typedef struct packed {
        logic [ADC_DATA_W-1:0] ch1;
        logic [ADC_DATA_W-1:0] ch0;
    } adc_pair_t;

    // Half an LSB of the averaged result, so the shift rounds half-up instead of truncating.
    function automatic int round_term(input int log2_avg);
        return (log2_avg == 0) ? 0 : (1 << (log2_avg - 1));
    endfunction

endpackage

// File: rtl/adc_avg_lane.sv
// One channel of the boxcar averager: accumulator plus rounded divide-by-window.
// Window counting and output handshake live in the parent; this lane only adds and clears.
module adc_avg_lane
    import adc_pkg::*;
#(
    parameter int DATA_W   = ADC_DATA_W,
    parameter int LOG2_AVG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg
);

    localparam int ACC_W = DATA_W + LOG2_AVG;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [SUM_W-1:0] RND = SUM_W'(round_term(LOG2_AVG));

    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] rounded;

    // avg is only meaningful on the completing strobe: it includes the sample arriving now.
    always_comb begin
        sum     = {1'b0, acc} + SUM_W'(sample);
        rounded = sum + RND;
        avg     = DATA_W'(rounded >> LOG2_AVG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= ACC_W'(sum);
        end
    end

endmodule

// File: rtl/adc_avg_filter.sv
// Dual-channel boxcar averaging filter with a one-entry valid/ready output register
// and a sticky overrun flag plus saturating count of averages lost to backpressure.
module adc_avg_filter
    import adc_pkg::*;
#(
    parameter int DATA_W   = ADC_DATA_W,
    parameter int LOG2_AVG = 4,
    parameter int DROP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample0_i,
    input  logic [DATA_W-1:0] sample1_i,
    output logic              avg_valid_o,
    input  logic              avg_ready_i,
    output logic [DATA_W-1:0] avg0_o,
    output logic [DATA_W-1:0] avg1_o,
    output logic              overrun_o,
    input  logic              clr_overrun_i,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int WIN   = 1 << LOG2_AVG;
    localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

    logic [CNT_W-1:0]  cnt;
    logic              add;
    logic              complete;
    logic              win_clr;
    logic              accept;
    logic              can_load;
    logic              load;
    logic              drop;
    logic [DATA_W-1:0] lane_avg0;
    logic [DATA_W-1:0] lane_avg1;

    // The counter never reaches WIN; the strobe seen at WIN-1 closes the window.
    always_comb begin
        add      = en_i & sample_valid_i;
        complete = add & (cnt == CNT_W'(WIN - 1));
        win_clr  = ~en_i | complete;
        accept   = avg_valid_o & avg_ready_i;
        can_load = ~avg_valid_o | avg_ready_i;
        load     = complete & can_load;
        drop     = complete & ~can_load;
    end

    adc_avg_lane #(
        .DATA_W   (DATA_W),
        .LOG2_AVG (LOG2_AVG)
    ) u_lane0 (
        .clk    (clk),
        .rst    (rst),
        .clr    (win_clr),
        .add    (add),
        .sample (sample0_i),
        .avg    (lane_avg0)
    );

    adc_avg_lane #(
        .DATA_W   (DATA_W),
        .LOG2_AVG (LOG2_AVG)
    ) u_lane1 (
        .clk    (clk),
        .rst    (rst),
        .clr    (win_clr),
        .add    (add),
        .sample (sample1_i),
        .avg    (lane_avg1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (win_clr) begin
            cnt <= '0;
        end else if (add) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A transfer on the completion cycle frees the slot for the new average.
    always_ff @(posedge clk) begin
        if (rst) begin
            avg_valid_o <= 1'b0;
            avg0_o      <= '0;
            avg1_o      <= '0;
        end else if (load) begin
            avg_valid_o <= 1'b1;
            avg0_o      <= lane_avg0;
            avg1_o      <= lane_avg1;
        end else if (accept) begin
            avg_valid_o <= 1'b0;
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_o  <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overrun_o <= 1'b1;
            if (clr_overrun_i) begin
                drop_cnt_o <= DROP_W'(1);
            end else if (!(&drop_cnt_o)) begin
                drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            end
        end else if (clr_overrun_i) begin
            overrun_o  <= 1'b0;
            drop_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_adc_avg_filter.sv
// Bench for adc_avg_filter: a window/queue model checked every cycle, plus
// hand-computed literal checks; a second pass-through instance uses LOG2_AVG=0.
module tb_adc_avg_filter;

    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        rst, en, sv, ready, clr;
    logic [11:0] s0, s1;

    logic        a_valid, a_ovr;
    logic [11:0] a_avg0, a_avg1;
    logic [7:0]  a_drop;
    logic        b_valid, b_ovr;
    logic [11:0] b_avg0, b_avg1;
    logic [7:0]  b_drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_avg_filter #(.DATA_W(12), .LOG2_AVG(2), .DROP_W(8)) dut_a (
        .clk(clk), .rst(rst), .en_i(en), .sample_valid_i(sv),
        .sample0_i(s0), .sample1_i(s1),
        .avg_valid_o(a_valid), .avg_ready_i(ready),
        .avg0_o(a_avg0), .avg1_o(a_avg1),
        .overrun_o(a_ovr), .clr_overrun_i(clr), .drop_cnt_o(a_drop)
    );

    adc_avg_filter #(.DATA_W(12), .LOG2_AVG(0), .DROP_W(8)) dut_b (
        .clk(clk), .rst(rst), .en_i(en), .sample_valid_i(sv),
        .sample0_i(s0), .sample1_i(s1),
        .avg_valid_o(b_valid), .avg_ready_i(1'b1),
        .avg0_o(b_avg0), .avg1_o(b_avg1),
        .overrun_o(b_ovr), .clr_overrun_i(clr), .drop_cnt_o(b_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collect a window of samples, average with half-up rounding.
    int   q0[$], q1[$];
    logic m_valid, m_ovr, p_valid;
    int   m_avg0, m_avg1, m_drop, p_avg0, p_avg1;

    always @(posedge clk) begin
        bit done;
        int sum0, sum1, n0, n1;
        done = 0;
        n0 = 0;
        n1 = 0;
        if (rst) begin
            q0.delete(); q1.delete();
            m_valid = 0; m_avg0 = 0; m_avg1 = 0; m_ovr = 0; m_drop = 0;
            p_valid = 0; p_avg0 = 0; p_avg1 = 0;
        end else begin
            p_valid = en && sv;
            if (p_valid) begin
                p_avg0 = int'(s0);
                p_avg1 = int'(s1);
            end
            if (!en) begin
                q0.delete(); q1.delete();
            end else if (sv) begin
                q0.push_back(int'(s0));
                q1.push_back(int'(s1));
                if (q0.size() == WIN) begin
                    sum0 = 0; sum1 = 0;
                    foreach (q0[i]) sum0 += q0[i];
                    foreach (q1[i]) sum1 += q1[i];
                    n0 = (sum0 + WIN / 2) / WIN;
                    n1 = (sum1 + WIN / 2) / WIN;
                    done = 1;
                    q0.delete(); q1.delete();
                end
            end
            if (done && (!m_valid || ready)) begin
                m_valid = 1; m_avg0 = n0; m_avg1 = n1;
                if (clr) begin m_ovr = 0; m_drop = 0; end
            end else if (done) begin
                m_ovr  = 1;
                m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
            end else begin
                if (m_valid && ready) m_valid = 0;
                if (clr) begin m_ovr = 0; m_drop = 0; end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        check("valid", a_valid, m_valid);
        if (m_valid) begin
            check("avg0", a_avg0, m_avg0);
            check("avg1", a_avg1, m_avg1);
        end
        check("overrun", a_ovr, m_ovr);
        check("drop_cnt", a_drop, m_drop);
        check("pt_valid", b_valid, p_valid);
        if (p_valid) begin
            check("pt_avg0", b_avg0, p_avg0);
            check("pt_avg1", b_avg1, p_avg1);
        end
        check("pt_overrun", b_ovr, 0);
        check("pt_drop_cnt", b_drop, 0);
    end

    task automatic cyc(input logic v, input int a, input int b);
        @(negedge clk);
        sv = v;
        s0 = 12'(a);
        s1 = 12'(b);
    endtask

    initial begin
        rst = 1; en = 0; sv = 0; s0 = 0; s1 = 0; ready = 0; clr = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", a_valid, 0);
        check("rst_avg0", a_avg0, 0);
        check("rst_overrun", a_ovr, 0);
        check("rst_drop", a_drop, 0);
        rst = 0; en = 1; ready = 1;

        // rounding
        cyc(1, 100, 0); cyc(1, 101, 0); cyc(1, 101, 0); cyc(1, 101, 2);
        cyc(0, 0, 0);
        check("t1_valid", a_valid, 1);
        check("t1_avg0", a_avg0, 101);
        check("t1_avg1", a_avg1, 1);
        cyc(0, 0, 0);
        check("t1_consumed", a_valid, 0);

        // full scale and pass-through
        cyc(1, 4095, 4095); cyc(1, 4095, 4095);
        check("t2_pt_fs", b_avg0, 4095);
        cyc(1, 4095, 4095); cyc(1, 4095, 4095);
        cyc(0, 0, 0);
        check("t2_fs_avg0", a_avg0, 4095);
        check("t2_fs_avg1", a_avg1, 4095);
        cyc(1, 1234, 77); cyc(1, 10, 20);
        check("t2_pt_valid", b_valid, 1);
        check("t2_pt_avg0", b_avg0, 1234);
        check("t2_pt_avg1", b_avg1, 77);
        cyc(1, 30, 40); cyc(1, 50, 60);
        cyc(0, 0, 0);
        check("t2_avg0", a_avg0, 331);
        check("t2_avg1", a_avg1, 49);
        check("t2_pt_last", b_avg0, 50);
        cyc(0, 0, 0); cyc(0, 0, 0);

        // backpressure, clear, clear colliding with a drop
        ready = 0;
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++) cyc(1, 40 * (w + 1), w);
        cyc(0, 0, 0);
        check("t3_valid", a_valid, 1);
        check("t3_held", a_avg0, 40);
        check("t3_overrun", a_ovr, 1);
        check("t3_drop", a_drop, 2);
        clr = 1; cyc(0, 0, 0); clr = 0;
        check("t3_clr_ovr", a_ovr, 0);
        check("t3_clr_drop", a_drop, 0);
        check("t3_clr_valid", a_valid, 1);
        check("t3_clr_held", a_avg0, 40);
        cyc(1, 200, 0); cyc(1, 200, 0); cyc(1, 200, 0); cyc(1, 200, 0);
        clr = 1; cyc(0, 0, 0); clr = 0;
        check("t3_dropwin_ovr", a_ovr, 1);
        check("t3_dropwin_cnt", a_drop, 1);
        clr = 1; cyc(0, 0, 0); clr = 0;
        ready = 1; cyc(0, 0, 0);
        check("t3_drained", a_valid, 0);

        // ready exactly on the completion cycle
        ready = 0;
        for (int k = 0; k < 4; k++) cyc(1, 5, 5);
        cyc(1, 9, 9); cyc(1, 9, 9); cyc(1, 9, 9); cyc(1, 9, 9);
        ready = 1; cyc(0, 0, 0); ready = 0;
        check("t4_valid", a_valid, 1);
        check("t4_avg0", a_avg0, 9);
        check("t4_drop", a_drop, 0);
        ready = 1; cyc(0, 0, 0); cyc(0, 0, 0);

        // enable flush with a strobe while disabled
        cyc(1, 1000, 1000); cyc(1, 1000, 1000);
        cyc(1, 500, 500); en = 0;
        cyc(1, 8, 8); en = 1;
        check("t5_pt_ignored", b_valid, 0);
        cyc(1, 8, 8); cyc(1, 8, 8); cyc(1, 8, 8);
        cyc(0, 0, 0);
        check("t5_valid", a_valid, 1);
        check("t5_avg0", a_avg0, 8);
        check("t5_avg1", a_avg1, 8);
        cyc(0, 0, 0);

        // reset with pending output, overrun and a partial window
        ready = 0;
        for (int k = 0; k < 4; k++) cyc(1, 20, 20);
        for (int k = 0; k < 4; k++) cyc(1, 30, 30);
        cyc(1, 3, 3); cyc(1, 3, 3); rst = 1;
        cyc(0, 0, 0); rst = 0;
        check("t6_valid", a_valid, 0);
        check("t6_avg0", a_avg0, 0);
        check("t6_avg1", a_avg1, 0);
        check("t6_overrun", a_ovr, 0);
        check("t6_drop", a_drop, 0);
        check("t6_pt_avg0", b_avg0, 0);
        en = 1; ready = 1;
        cyc(1, 7, 1); cyc(1, 7, 2); cyc(1, 7, 3); cyc(1, 8, 4);
        cyc(0, 0, 0);
        check("t6_avg0_after", a_avg0, 7);
        check("t6_avg1_after", a_avg1, 3);
        cyc(0, 0, 0);

        // drop counter saturation
        ready = 0;
        for (int w = 0; w < 260; w++)
            for (int k = 0; k < 4; k++) cyc(1, w % 16, 1);
        cyc(0, 0, 0);
        check("t7_sat", a_drop, 255);
        check("t7_overrun", a_ovr, 1);
        check("t7_held", a_avg0, 0);
        clr = 1; cyc(0, 0, 0); clr = 0;
        ready = 1; cyc(0, 0, 0); cyc(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
